sub_halt_ctrl: RTL
==================

Name: sub_halt_ctrl

Overview:
- Main-to-sub CPU halt/cancel handshake controller for the FM-7 sub-system.
- Owns the $FD05 main-side register and drives the sub 6809 HALT pin.
- Qualifies halt acknowledge from sub BA/BS and produces SHALTACn, which grants the main CPU access to sub shared RAM.
- Also holds the sub BUSY flag and the cancel request to the sub CPU.

Parameters:
- ACK_DELAY, 2: consecutive cycles BA=BS=1 must be stable before SHALTACn asserts; legal range 1..15.
- CNT_W, 4: width of the acknowledge qualification counter.

Ports:
- CLKSYS  in  1  system clock; all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MWT_FD05  in  1  one-cycle main-CPU write strobe to $FD05, already address/phase qualified.
- MRD_FD05  in  1  one-cycle main-CPU read strobe of $FD05; informational, no side effects.
- MDATA_in  in  8  main data bus; bit7 = halt request, bit6 = cancel request.
- SUB_BA  in  1  sub 6809 BA pin.
- SUB_BS  in  1  sub 6809 BS pin.
- SRD_D40A  in  1  one-cycle sub read strobe of $D40A; sets BUSY.
- SWT_D40A  in  1  one-cycle sub write strobe of $D40A; clears BUSY.
- SRD_D402  in  1  one-cycle sub read strobe of $D402; clears CANCEL.
- SHALTn  out  1  to sub CPU HALT input, active low.
- SHALTACn  out  1  halt granted, active low; feeds shared-RAM address/data mux and write enable.
- SCANCEL  out  1  cancel interrupt request to sub CPU, active high, level.
- FD05_out  out  8  main read data for $FD05.

Behaviour:
- Reset (async, immediate):
  - state=RUN, hreq=0, SCANCEL=0, busy=1, cnt=0.
  - SHALTn=1, SHALTACn=1.
  - Reset mid-halt releases the sub at once.
- Register writes: MWT_FD05 loads hreq<=MDATA_in[7].
  - MDATA_in[6]=1 sets SCANCEL.
  - MDATA_in[6]=0 leaves SCANCEL unchanged.
- SCANCEL:
  - Cleared by SRD_D402.
  - Set and clear in the same cycle: set wins.
- busy:
  - Set by SRD_D40A, cleared by SWT_D40A.
  - Both in the same cycle: clear wins (write wins).
- FD05_out:
  - Combinational.
  - bit7 = busy | ~SHALTACn.
  - bits6..1 = 1.
  - bit0 = 0 (no extension card).
- All other outputs are registered.
- FSM, all transitions on the clock edge:
  - RUN:
    - SHALTn=1, SHALTACn=1, cnt=0.
    - hreq=1 -> REQ.
  - REQ:
    - SHALTn=0.
    - If BA&BS: cnt++ (saturating); else cnt=0.
    - When cnt reaches ACK_DELAY-1 with BA&BS still high -> HALTED, so SHALTACn falls exactly ACK_DELAY cycles after BA&BS first seen high.
    - hreq=0 while in REQ -> RELEASE; SHALTACn never asserts.
  - HALTED:
    - SHALTn=0, SHALTACn=0.
    - hreq=0 -> RELEASE; SHALTACn=1 registered on entry to RELEASE.
    - BA or BS dropping while HALTED is a protocol error -> RELEASE with SHALTACn=1.
    - Re-request from RELEASE follows the normal path.
  - RELEASE:
    - SHALTn=1, SHALTACn=1.
    - When BA=0 and BS=0 -> RUN.
    - hreq=1 arriving in RELEASE is held; it is taken as RUN->REQ on the cycle after reaching RUN.
- Rewriting hreq=1 while in REQ/HALTED has no effect on the FSM.
- Invariant: SHALTACn=0 only while SHALTn=0.
- cnt width is CNT_W; no wrap, saturates at 2^CNT_W-1.

Test Plan:
- Reset value check:
  - Assert RESET mid-cycle -> SHALTn=1, SHALTACn=1, SCANCEL=0, FD05_out=8'hFE immediately, without a clock edge.
- Nominal halt, ACK_DELAY=2:
  - Write $FD05=8'h80 -> SHALTn=0 next cycle.
  - Drive BA=BS=1 from cycle 3 -> SHALTACn=0 at cycle 5.
  - Write 8'h00 -> SHALTACn=1 next cycle.
  - Drop BA/BS -> state RUN, SHALTn=1.
- Aborted request:
  - Write 8'h80, then 8'h00 before BA/BS rise -> SHALTACn stays 1 throughout; SHALTn returns to 1 one cycle after the 8'h00 write.
- Glitchy ack:
  - BA=BS=1 for 1 cycle, low 1 cycle, then high 2 cycles -> SHALTACn falls only after the 2 consecutive cycles.
- Cancel and busy:
  - Write 8'h40 -> SCANCEL=1; a later write of 8'h00 keeps it at 1.
  - SRD_D402 -> SCANCEL=0.
  - Same-cycle 8'h40 write and SRD_D402 -> SCANCEL=1.
  - SWT_D40A -> FD05_out=8'h7E; SRD_D40A -> 8'hFE.
  - Same-cycle SRD_D40A and SWT_D40A -> 8'h7E.
- Re-request during RELEASE:
  - Write 8'h00 then 8'h80 while BA=BS still 1 -> SHALTn stays 1 until BA=BS=0, then falls 2 cycles after (RUN then REQ).

Source files
------------

// File: rtl/sub_halt_ctrl.sv
// sub_halt_ctrl: FM-7 main-to-sub halt/cancel handshake; owns $FD05, drives sub HALT and SHALTACn.
module sub_halt_ctrl #(
  parameter int ACK_DELAY = 2,
  parameter int CNT_W = 4
) (
  input  logic       CLKSYS,
  input  logic       RESET,
  input  logic       MWT_FD05,
  input  logic       MRD_FD05,
  input  logic [7:0] MDATA_in,
  input  logic       SUB_BA,
  input  logic       SUB_BS,
  input  logic       SRD_D40A,
  input  logic       SWT_D40A,
  input  logic       SRD_D402,
  output logic       SHALTn,
  output logic       SHALTACn,
  output logic       SCANCEL,
  output logic [7:0] FD05_out
);
  typedef enum logic [1:0] {ST_RUN, ST_REQ, ST_HALTED, ST_RELEASE} state_t;
  state_t state_q, state_d;
  logic hreq_q, hreq_d, busy_q, busy_d, cancel_q, cancel_d;
  logic shaltn_q, shaltn_d, shaltacn_q, shaltacn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ack, unused_in;
  assign unused_in = ^{MRD_FD05, MDATA_in[5:0]};
  assign ack = SUB_BA & SUB_BS;
  // A write in this cycle acts on the FSM immediately, so SHALTn follows the write by one edge.
  always_comb begin
    hreq_d = MWT_FD05 ? MDATA_in[7] : hreq_q;
    cancel_d = (MWT_FD05 & MDATA_in[6]) ? 1'b1 : SRD_D402 ? 1'b0 : cancel_q;
    busy_d = SWT_D40A ? 1'b0 : SRD_D40A ? 1'b1 : busy_q;
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      ST_RUN: state_d = hreq_d ? ST_REQ : ST_RUN;
      ST_REQ: begin
        cnt_d = !ack ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        state_d = !hreq_d ? ST_RELEASE :
                  (ack && cnt_q == CNT_W'(ACK_DELAY - 1)) ? ST_HALTED : ST_REQ;
      end
      ST_HALTED: state_d = (!hreq_d || !ack) ? ST_RELEASE : ST_HALTED;
      default: state_d = (!SUB_BA && !SUB_BS) ? ST_RUN : ST_RELEASE;
    endcase
    if (state_d != ST_REQ) cnt_d = '0;
    shaltn_d = !(state_d == ST_REQ || state_d == ST_HALTED);
    shaltacn_d = state_d != ST_HALTED;
  end
  always_ff @(posedge CLKSYS or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      hreq_q <= 1'b0;
      cancel_q <= 1'b0;
      busy_q <= 1'b1;
      cnt_q <= '0;
      shaltn_q <= 1'b1;
      shaltacn_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hreq_q <= hreq_d;
      cancel_q <= cancel_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      shaltn_q <= shaltn_d;
      shaltacn_q <= shaltacn_d;
    end
  end
  assign SHALTn = shaltn_q;
  assign SHALTACn = shaltacn_q;
  assign SCANCEL = cancel_q;
  assign FD05_out = {busy_q | ~shaltacn_q, 6'b111111, 1'b0};
endmodule
